// File: rtl/rf_pkg.sv
// Shared constants and the sweep FSM state encoding for the multi-port register file.
package rf_pkg;

  localparam int RF_DW   = 32;
  localparam int RF_NREG = 32;

  // Soft-clear sweep FSM states.
  localparam logic [0:0] RF_IDLE  = 1'b0;
  localparam logic [0:0] RF_SWEEP = 1'b1;

  // Register address width. This never returns less than one bit.
  function automatic int rf_aw(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/rf_mp_sb_if.sv
// Register file access bus: read ports, write ports, scoreboard controls, sweep control.
interface rf_mp_sb_if
  import rf_pkg::*;
#(
  parameter int DW  = RF_DW,
  parameter int AW  = rf_aw(RF_NREG),
  parameter int NRP = 2,
  parameter int NWP = 1
);

  logic [NRP*AW-1:0] rd_addr;
  logic [NRP*DW-1:0] rd_data;
  logic [NRP-1:0]    rd_busy;
  logic [NWP-1:0]    wr_en;
  logic [NWP*AW-1:0] wr_addr;
  logic [NWP*DW-1:0] wr_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic              sb_flush;
  logic              clr_req;
  logic              ready;

  // The pipeline side drives requests and consumes read data and status.
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, sb_flush, clr_req,
    input  rd_data, rd_busy, ready
  );

  // The register file side.
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, sb_flush, clr_req,
    output rd_data, rd_busy, ready
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: reserve on issue, clear on write, flush, and sweep clear.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG     = RF_NREG,
  parameter int AW       = rf_aw(RF_NREG),
  parameter int NRP      = 2,
  parameter int NWP      = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ready,
  input  logic [NWP-1:0]    wr_en,
  input  logic [NWP*AW-1:0] wr_addr,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic              sb_flush,
  input  logic [AW-1:0]     swp_ptr,
  input  logic [NRP*AW-1:0] rd_addr,
  output logic [NRP-1:0]    rd_busy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  // Next busy vector: flush, then write clears, then reserve sets, so a new producer wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    busy_nxt = busy;
    if (ready) begin
      if (sb_flush) busy_nxt = '0;
      for (int w = 0; w < NWP; w++) begin
        if (wr_en[w]) busy_nxt[wr_addr[w*AW +: AW]] = 1'b0;
      end
      if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
    end else begin
      busy_nxt[swp_ptr] = 1'b0;
    end
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  // Busy state register, updated on the falling edge like the rest of the file.
  always_ff @(negedge clk or negedge rst) begin
    // NOTE: state is written with <= only; = here would let readers in the same edge see the new value.
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end

  // Per-read-port busy lookup.
  always_comb begin
    rd_busy = '0;
    for (int p = 0; p < NRP; p++) begin
      rd_busy[p] = busy[rd_addr[p*AW +: AW]];
    end
  end

endmodule

// File: rtl/rf_mp_sb.sv
// Multi-port register file with write-to-read bypass, busy scoreboard and soft-clear sweep.
// All state changes on the falling clock edge; reads are purely combinational.
module rf_mp_sb
  import rf_pkg::*;
#(
  parameter int DW       = RF_DW,
  parameter int NREG     = RF_NREG,
  parameter int NRP      = 2,
  parameter int NWP      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic       clk,
  input  logic       rst,
  rf_mp_sb_if.slave  bus
);

  localparam int            AW        = rf_aw(NREG);
  localparam logic [AW-1:0] PTR_FIRST = (ZERO_REG != 0) ? AW'(1) : '0;
  localparam logic [AW-1:0] PTR_LAST  = AW'(NREG - 1);

  logic [DW-1:0]   rf [NREG];
  logic [0:0]      state;
  logic [AW-1:0]   ptr;
  logic            ready;
  logic [NREG-1:0] we;
  logic [DW-1:0]   wd [NREG];
  logic [NRP-1:0]  sb_busy;
  logic [NRP-1:0]  fwd;

  assign ready     = (state == RF_IDLE);
  assign bus.ready = ready;

  // Sweep FSM: walks ptr over every clearable register once, then returns to idle.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state <= RF_IDLE;
      ptr   <= '0;
    end else if (state == RF_IDLE) begin
      if (bus.clr_req) begin
        state <= RF_SWEEP;
        ptr   <= PTR_FIRST;
      end
    end else if (ptr == PTR_LAST) begin
      state <= RF_IDLE;
      ptr   <= '0;
    end else begin
      ptr <= ptr + 1'b1;
    end
  end

  // Per-register write select; later ports override earlier ones, so the highest index wins.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      we[i] = 1'b0;
      wd[i] = '0;
      for (int w = 0; w < NWP; w++) begin
        if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == AW'(i)) begin
          we[i] = 1'b1;
          wd[i] = bus.wr_data[w*DW +: DW];
        end
      end
    end
  end

  // Register array: sweep clears one entry per cycle, otherwise normal writes.
  always_ff @(negedge clk or negedge rst) begin
    // NOTE: the array takes the async reset on purpose: a reset must clear every register at once,
    // which rules out mapping it onto a RAM macro.
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (!ready) begin
          if (ptr == AW'(i)) rf[i] <= '0;
        end else if (we[i] && !(ZERO_REG != 0 && i == 0)) begin
          rf[i] <= wd[i];
        end
      end
    end
  end

  // Read muxes: hard zero first, then same-cycle bypass (idle only), then array contents.
  always_comb begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rdata;
    bus.rd_data = '0;
    fwd         = '0;
    for (int p = 0; p < NRP; p++) begin
      ra    = bus.rd_addr[p*AW +: AW];
      rdata = rf[ra];
      for (int w = 0; w < NWP; w++) begin
        if (BYPASS != 0 && ready && bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == ra) begin
          fwd[p] = 1'b1;
          rdata  = bus.wr_data[w*DW +: DW];
        end
      end
      if (ZERO_REG != 0 && ra == '0) begin
        fwd[p] = 1'b0;
        rdata  = '0;
      end
      bus.rd_data[p*DW +: DW] = rdata;
    end
  end

  rf_scoreboard #(
    .NREG     (NREG),
    .AW       (AW),
    .NRP      (NRP),
    .NWP      (NWP),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .sb_flush (bus.sb_flush),
    .swp_ptr  (ptr),
    .rd_addr  (bus.rd_addr),
    .rd_busy  (sb_busy)
  );

  // A forwarded write means the producer has just retired, so the operand is not busy.
  assign bus.rd_busy = sb_busy & ~fwd;

endmodule

// File: tb/tb_rf_mp_sb.sv
// Self-checking bench for rf_mp_sb: directed scenarios plus randomized traffic against an array model.
module tb_rf_mp_sb;
  import rf_pkg::*;

  localparam int DW   = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int NWP  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rf_mp_sb_if #(.DW(DW), .AW(AW), .NRP(NRP), .NWP(NWP)) bus ();

  rf_mp_sb #(
    .DW(DW), .NREG(NREG), .NRP(NRP), .NWP(NWP), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural register values, busy flags and sweep progress.
  logic [DW-1:0] m_rf   [NREG];
  bit            m_busy [NREG];
  bit            m_sweep;
  int            m_ptr;
  bit            s_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    d = m_rf[a];
    if (a == 0) return '0;
    if (!m_sweep)
      for (int w = 0; w < NWP; w++)
        if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == a) d = bus.wr_data[w*DW +: DW];
    return d;
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (!m_sweep)
      for (int w = 0; w < NWP; w++)
        if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_rf[r]   = '0;
      m_busy[r] = 1'b0;
    end
    m_sweep = 1'b0;
    m_ptr   = 0;
  endtask

  // Applies one falling edge's worth of architectural effects.
  task automatic model_update();
    int a;
    if (m_sweep) begin
      m_rf[m_ptr]   = '0;
      m_busy[m_ptr] = 1'b0;
      m_ptr++;
      if (m_ptr == NREG) m_sweep = 1'b0;
    end else begin
      if (bus.sb_flush) for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
      for (int w = 0; w < NWP; w++) begin
        if (bus.wr_en[w]) begin
          a = int'(bus.wr_addr[w*AW +: AW]);
          if (a != 0) m_rf[a] = bus.wr_data[w*DW +: DW];
          m_busy[a] = 1'b0;
        end
      end
      if (bus.rsv_en && bus.rsv_addr != 0) m_busy[bus.rsv_addr] = 1'b1;
      if (bus.clr_req) begin
        m_sweep = 1'b1;
        m_ptr   = 1;
      end
    end
  endtask

  task automatic check_outputs();
    for (int p = 0; p < NRP; p++) begin
      check($sformatf("rd_data%0d", p), bus.rd_data[p*DW +: DW], exp_data(bus.rd_addr[p*AW +: AW]));
      check($sformatf("rd_busy%0d", p), bus.rd_busy[p], exp_busy(bus.rd_addr[p*AW +: AW]));
    end
    check("ready", bus.ready, !m_sweep);
  endtask

  // One clock: check combinational outputs mid-cycle, let the falling edge commit, update the model.
  task automatic step();
    @(posedge clk);
    #1;
    check_outputs();
    s_ready = bus.ready;
    @(negedge clk);
    #1;
    model_update();
  endtask

  task automatic idle_inputs();
    bus.rd_addr  = '0;
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
    bus.sb_flush = 1'b0;
    bus.clr_req  = 1'b0;
  endtask

  task automatic set_wr(input int w, input int a, input logic [DW-1:0] d);
    bus.wr_en[w]             = 1'b1;
    bus.wr_addr[w*AW +: AW]  = AW'(a);
    bus.wr_data[w*DW +: DW]  = d;
  endtask

  task automatic set_rd(input int p, input int a);
    bus.rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_rsv(input int a);
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = AW'(a);
  endtask

  task automatic peek(input string tag, input int a, input logic [DW-1:0] d, input bit b);
    set_rd(0, a);
    #1;
    check({tag, "_data"}, bus.rd_data[DW-1:0], d);
    check({tag, "_busy"}, bus.rd_busy[0], b);
  endtask

  task automatic peek_busy(input string tag, input int a, input bit b);
    set_rd(0, a);
    #1;
    check(tag, bus.rd_busy[0], b);
  endtask

  function automatic int rand_addr();
    return ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, NREG - 1);
  endfunction

  // Random traffic; clr_odds == 0 disables clear requests.
  task automatic rand_inputs(input int clr_odds);
    for (int w = 0; w < NWP; w++) begin
      bus.wr_en[w]            = 1'($urandom_range(0, 1));
      bus.wr_addr[w*AW +: AW] = AW'(rand_addr());
      bus.wr_data[w*DW +: DW] = $urandom;
    end
    for (int p = 0; p < NRP; p++) begin
      if ($urandom_range(0, 2) == 0) bus.rd_addr[p*AW +: AW] = bus.wr_addr[($urandom_range(0, NWP - 1))*AW +: AW];
      else                           bus.rd_addr[p*AW +: AW] = AW'(rand_addr());
    end
    bus.rsv_en   = 1'($urandom_range(0, 1));
    bus.rsv_addr = AW'(rand_addr());
    bus.sb_flush = ($urandom_range(0, 19) == 0);
    bus.clr_req  = (clr_odds > 0) && ($urandom_range(0, clr_odds - 1) == 0);
  endtask

  task automatic wait_idle();
    idle_inputs();
    for (int k = 0; k < 40 && m_sweep; k++) step();
    check("wait_idle", m_sweep, 1'b0);
  endtask

  initial begin
    int cnt;
    idle_inputs();
    model_reset();
    #2;
    check("rst_ready", bus.ready, 1'b1);
    check("rst_rd_data", bus.rd_data, '0);
    check("rst_rd_busy", bus.rd_busy, '0);
    #10 rst = 1'b1;
    @(negedge clk);
    #1;

    // T1: write then read back, and x0 reads zero.
    set_wr(0, 5, 32'hDEADBEEF);
    step();
    idle_inputs();
    peek("t1_x5", 5, 32'hDEADBEEF, 1'b0);
    peek("t1_x0", 0, '0, 1'b0);

    // T2: same-cycle bypass hides a pending reservation.
    set_rsv(7);
    step();
    idle_inputs();
    peek_busy("t2_busy_before", 7, 1'b1);
    set_wr(0, 7, 32'h1234);
    set_rd(0, 7);
    #1;
    check("t2_bypass_data", bus.rd_data[DW-1:0], 32'h1234);
    check("t2_bypass_busy", bus.rd_busy[0], 1'b0);
    step();
    idle_inputs();

    // T3: write-port priority and the hard-wired zero register.
    set_wr(0, 3, 32'hAA);
    set_wr(1, 3, 32'hBB);
    set_rd(1, 3);
    step();
    idle_inputs();
    peek("t3_x3", 3, 32'hBB, 1'b0);
    set_wr(0, 0, 32'hFF);
    step();
    idle_inputs();
    peek("t3_x0", 0, '0, 1'b0);

    // T4: reserve, write+reserve (set wins), write clears, flush with reserve.
    set_rsv(9);
    step();
    idle_inputs();
    peek_busy("t4_rsv", 9, 1'b1);
    set_wr(0, 9, 32'h1);
    set_rsv(9);
    step();
    idle_inputs();
    peek_busy("t4_set_wins", 9, 1'b1);
    set_wr(1, 9, 32'h2);
    step();
    idle_inputs();
    peek_busy("t4_wr_clears", 9, 1'b0);
    set_rsv(10);
    step();
    set_rsv(11);
    step();
    idle_inputs();
    peek_busy("t4_rsv10", 10, 1'b1);
    bus.sb_flush = 1'b1;
    set_rsv(12);
    step();
    idle_inputs();
    peek_busy("t4_flush10", 10, 1'b0);
    peek_busy("t4_flush11", 11, 1'b0);
    peek_busy("t4_flush_rsv12", 12, 1'b1);

    // T5: fill, sweep, writes during the sweep are dropped, everything ends at zero.
    for (int r = 1; r < NREG; r++) begin
      idle_inputs();
      set_wr(0, r, $urandom | 32'h1);
      set_rsv(r);
      step();
    end
    idle_inputs();
    bus.clr_req = 1'b1;
    step();
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      idle_inputs();
      if (m_sweep) begin
        set_wr(0, $urandom_range(1, NREG - 1), $urandom | 32'h1);
        set_wr(1, $urandom_range(1, NREG - 1), $urandom | 32'h1);
        set_rsv($urandom_range(1, NREG - 1));
        set_rd(0, $urandom_range(0, NREG - 1));
        set_rd(1, bus.wr_addr[AW-1:0]);
        bus.clr_req = (k == 5);
      end
      step();
      if (!s_ready) cnt++;
    end
    check("t5_sweep_cycles", cnt, NREG - 1);
    idle_inputs();
    for (int r = 0; r < NREG; r++) peek($sformatf("t5_x%0d", r), r, '0, 1'b0);

    // Randomized traffic, including sweeps and clear requests during sweeps.
    for (int k = 0; k < 1500; k++) begin
      rand_inputs(60);
      step();
    end

    // T6: reset in the middle of a sweep.
    wait_idle();
    for (int k = 0; k < 60; k++) begin
      rand_inputs(0);
      step();
    end
    idle_inputs();
    bus.clr_req = 1'b1;
    step();
    idle_inputs();
    for (int k = 0; k < 40 && m_ptr < 12; k++) step();
    check("t6_ptr", m_ptr, 12);
    check("t6_sweeping", bus.ready, 1'b0);
    rst = 1'b0;
    #1;
    check("t6_ready", bus.ready, 1'b1);
    for (int r = 0; r < NREG; r++) begin
      set_rd(0, r);
      set_rd(1, NREG - 1 - r);
      #1;
      check($sformatf("t6_data_x%0d", r), bus.rd_data, '0);
      check($sformatf("t6_busy_x%0d", r), bus.rd_busy, '0);
    end
    model_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #1;
    for (int k = 0; k < 200; k++) begin
      rand_inputs(60);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
